// File: rtl/vidtiming_if.sv
// ---------------------------------------------------------------------------
// vidtiming_if
//   Bundle between the raster timing generator and its consumers
//   (vidctrl drives the requests; tilegen, sprite and mixer stages read timing).
//   There is no valid/ready handshake: every timing signal is valid on every
//   clk, and the two requests are plain levels sampled on every clk.
//
//   Signals
//     flip_ena   consumer -> timing  screen flip request
//     nmi_ena    consumer -> timing  vblank NMI enable / clear
//     htiming    timing -> consumer  horizontal count [9:0]
//     vtiming    timing -> consumer  raw vertical count [8:0]
//     vtiming_f  timing -> consumer  flip-adjusted vertical count [7:0]
//     flip_out   timing -> consumer  frame-latched flip
//     hblank, vblank, cmpblk         blanking decodes
//     hsync_n, vsync_n               active-low syncs
//     frame_stb                      one-clk pulse at vblank start
//     nmi_n                          active-low CPU NMI
//
//   Modports
//     master  the timing generator
//     slave   the consumer / controller side
// ---------------------------------------------------------------------------
interface vidtiming_if;
    logic       flip_ena;
    logic       nmi_ena;
    logic [9:0] htiming;
    logic [8:0] vtiming;
    logic [7:0] vtiming_f;
    logic       flip_out;
    logic       hblank;
    logic       vblank;
    logic       cmpblk;
    logic       hsync_n;
    logic       vsync_n;
    logic       frame_stb;
    logic       nmi_n;

    modport master (
        input  flip_ena, nmi_ena,
        output htiming, vtiming, vtiming_f, flip_out, hblank, vblank,
               cmpblk, hsync_n, vsync_n, frame_stb, nmi_n
    );

    modport slave (
        output flip_ena, nmi_ena,
        input  htiming, vtiming, vtiming_f, flip_out, hblank, vblank,
               cmpblk, hsync_n, vsync_n, frame_stb, nmi_n
    );
endinterface

// File: rtl/vidtiming.sv
// ---------------------------------------------------------------------------
// vidtiming
//   Raster timing generator on the 2x pixel clock. Produces the horizontal
//   and vertical counts, the flip-adjusted vertical count, blanking, syncs,
//   a frame strobe at vblank start and (optionally) the CPU vblank NMI.
//
//   Every output is registered from the *next* counter values, so all
//   decodes change on the same clk as htiming/vtiming (zero skew).
//
//   Ports
//     clk   in   2x pixel clock
//     rst   in   asynchronous reset, active high
//     vt    vidtiming_if.master (see rtl/vidtiming_if.sv)
//
//   Build option
//     VIDTIMING_NMI_EN  when defined, nmi_n is driven from frame_stb and
//                       nmi_ena; otherwise nmi_n is held 1 and nmi_ena is
//                       ignored.
//
//   H_ACTIVE is the first horizontal blank clock; with the default 512 this
//   is exactly htiming[9].
// ---------------------------------------------------------------------------
module vidtiming #(
    parameter int H_TOTAL  = 768,
    parameter int H_ACTIVE = 512,
    parameter int HS_START = 'h240,
    parameter int HS_LEN   = 64,
    parameter int V_TOTAL  = 264,
    parameter int VA_START = 16,
    parameter int VA_END   = 240,
    parameter int VS_START = 248,
    parameter int VS_LEN   = 8
) (
    input  logic           clk,
    input  logic           rst,
    vidtiming_if.master    vt
);

    // Elaboration-time sanity on the compare values.
    if (HS_START + HS_LEN > H_TOTAL) begin : g_bad_hsync
        $error("vidtiming: HS_START+HS_LEN exceeds H_TOTAL");
    end
    if (VS_START + VS_LEN > V_TOTAL) begin : g_bad_vsync
        $error("vidtiming: VS_START+VS_LEN exceeds V_TOTAL");
    end
    if (H_ACTIVE > H_TOTAL || VA_END > V_TOTAL || VA_START > VA_END) begin : g_bad_active
        $error("vidtiming: active window outside the raster");
    end

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] HS_BEG   = 10'(HS_START);
    localparam logic [9:0] HS_END   = 10'(HS_START + HS_LEN);
    localparam logic [8:0] V_LAST   = 9'(V_TOTAL - 1);
    localparam logic [8:0] VA_BEG   = 9'(VA_START);
    localparam logic [8:0] VA_STOP  = 9'(VA_END);
    localparam logic [8:0] VS_BEG   = 9'(VS_START);
    localparam logic [8:0] VS_END   = 9'(VS_START + VS_LEN);

    // State registers
    logic [9:0] h_q;
    logic [8:0] v_q;
    logic [7:0] vf_q;
    logic       flip_q;
    logic       hblank_q;
    logic       vblank_q;
    logic       cmpblk_q;
    logic       hsync_n_q;
    logic       vsync_n_q;
    logic       stb_q;
    logic       nmi_n_q;

    // Next-state values
    logic [9:0] h_d;
    logic [8:0] v_d;
    logic       flip_d;
    logic       h_wrap;
    logic       f_wrap;
    logic       hblank_d;
    logic       vblank_d;
    logic       hsync_d;
    logic       vsync_d;
    logic       stb_d;

    always_comb begin
        h_wrap   = (h_q == H_LAST);
        f_wrap   = h_wrap && (v_q == V_LAST);
        h_d      = h_wrap ? 10'd0 : h_q + 10'd1;
        v_d      = v_q;
        if (h_wrap) begin
            v_d = (v_q == V_LAST) ? 9'd0 : v_q + 9'd1;
        end
        // Flip is only picked up on the wrap to (0,0), so a frame is never
        // drawn half flipped.
        flip_d   = f_wrap ? vt.flip_ena : flip_q;
        hblank_d = (h_d >= H_ACT);
        vblank_d = (v_d < VA_BEG) || (v_d >= VA_STOP);
        hsync_d  = (h_d >= HS_BEG) && (h_d < HS_END);
        vsync_d  = (v_d >= VS_BEG) && (v_d < VS_END);
        // Only a line change can enter VA_END, which makes this a
        // single-clk pulse at htiming=0.
        stb_d    = h_wrap && (v_d == VA_STOP);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_q       <= 10'd0;
            v_q       <= 9'd0;
            vf_q      <= 8'd0;
            flip_q    <= 1'b0;
            hblank_q  <= 1'b0;
            vblank_q  <= 1'b1;
            cmpblk_q  <= 1'b1;
            hsync_n_q <= 1'b1;
            vsync_n_q <= 1'b1;
            stb_q     <= 1'b0;
        end else begin
            h_q       <= h_d;
            v_q       <= v_d;
            vf_q      <= v_d[7:0] ^ {8{flip_d}};
            flip_q    <= flip_d;
            hblank_q  <= hblank_d;
            vblank_q  <= vblank_d;
            cmpblk_q  <= hblank_d | vblank_d;
            hsync_n_q <= ~hsync_d;
            vsync_n_q <= ~vsync_d;
            stb_q     <= stb_d;
        end
    end

`ifdef VIDTIMING_NMI_EN
    // Clear has priority: nmi_ena low forces nmi_n high even on the strobe
    // clk. A late enable waits for the next strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            nmi_n_q <= 1'b1;
        end else if (!vt.nmi_ena) begin
            nmi_n_q <= 1'b1;
        end else if (stb_d) begin
            nmi_n_q <= 1'b0;
        end
    end
`else
    logic nmi_ena_unused;
    assign nmi_ena_unused = vt.nmi_ena;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            nmi_n_q <= 1'b1;
        end else begin
            nmi_n_q <= 1'b1;
        end
    end
`endif

    assign vt.htiming   = h_q;
    assign vt.vtiming   = v_q;
    assign vt.vtiming_f = vf_q;
    assign vt.flip_out  = flip_q;
    assign vt.hblank    = hblank_q;
    assign vt.vblank    = vblank_q;
    assign vt.cmpblk    = cmpblk_q;
    assign vt.hsync_n   = hsync_n_q;
    assign vt.vsync_n   = vsync_n_q;
    assign vt.frame_stb = stb_q;
    assign vt.nmi_n     = nmi_n_q;

endmodule

// File: tb/tb_vidtiming.sv
// ---------------------------------------------------------------------------
// tb_vidtiming
//   Two instances share clk/rst:
//     u_s  shrunken raster (16 clks x 12 lines) so several whole frames,
//          flip latching and NMI behaviour fit in a short run
//     u_d  default parameters, used for the horizontal line: 0..767 wrap,
//          hblank at 0x200, hsync at 0x240..0x27F, vtiming 0 -> 1
//   Outputs are sampled on the falling edge; inputs change there too.
// ---------------------------------------------------------------------------
module tb_vidtiming;

    // Shrunken raster
    localparam int SH_TOT = 16;
    localparam int SH_ACT = 8;
    localparam int SHS_B  = 10;
    localparam int SHS_L  = 3;
    localparam int SV_TOT = 12;
    localparam int SVA_B  = 2;
    localparam int SVA_E  = 8;
    localparam int SVS_B  = 9;
    localparam int SVS_L  = 2;
    localparam int S_FRAME = SH_TOT * SV_TOT;   // 192 clks

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;
    int   k;

    vidtiming_if s_if ();
    vidtiming_if d_if ();

    vidtiming #(
        .H_TOTAL (SH_TOT), .H_ACTIVE(SH_ACT), .HS_START(SHS_B), .HS_LEN(SHS_L),
        .V_TOTAL (SV_TOT), .VA_START(SVA_B),  .VA_END  (SVA_E), .VS_START(SVS_B),
        .VS_LEN  (SVS_L)
    ) u_s (
        .clk (clk),
        .rst (rst),
        .vt  (s_if.master)
    );

    vidtiming u_d (
        .clk (clk),
        .rst (rst),
        .vt  (d_if.master)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s k=%0d observed=%0h expected=%0h", tag, k, got, exp);
        end
    endtask

    // Reset values for one instance
    task automatic chk_reset(input string who, input logic [9:0] h, input logic [8:0] v,
                             input logic [7:0] vf, input logic fo, input logic hb,
                             input logic vb, input logic cb, input logic hs,
                             input logic vs, input logic st, input logic nm);
        chk({who, "_rst_htiming"},   32'(h),  32'd0);
        chk({who, "_rst_vtiming"},   32'(v),  32'd0);
        chk({who, "_rst_vtiming_f"}, 32'(vf), 32'd0);
        chk({who, "_rst_flip_out"},  32'(fo), 32'd0);
        chk({who, "_rst_hblank"},    32'(hb), 32'd0);
        chk({who, "_rst_vblank"},    32'(vb), 32'd1);
        chk({who, "_rst_cmpblk"},    32'(cb), 32'd1);
        chk({who, "_rst_hsync_n"},   32'(hs), 32'd1);
        chk({who, "_rst_vsync_n"},   32'(vs), 32'd1);
        chk({who, "_rst_frame_stb"}, 32'(st), 32'd0);
        chk({who, "_rst_nmi_n"},     32'(nm), 32'd1);
    endtask

    task automatic chk_s_reset();
        chk_reset("s", s_if.htiming, s_if.vtiming, s_if.vtiming_f, s_if.flip_out,
                  s_if.hblank, s_if.vblank, s_if.cmpblk, s_if.hsync_n,
                  s_if.vsync_n, s_if.frame_stb, s_if.nmi_n);
    endtask

    task automatic chk_d_reset();
        chk_reset("d", d_if.htiming, d_if.vtiming, d_if.vtiming_f, d_if.flip_out,
                  d_if.hblank, d_if.vblank, d_if.cmpblk, d_if.hsync_n,
                  d_if.vsync_n, d_if.frame_stb, d_if.nmi_n);
    endtask

    initial begin
        int hs, vs, hd, vd;
        logic fm, nm, hb, vb;
        n_cmp = 0;
        n_bad = 0;
        k     = 0;

        // Step 1: reset state
        rst           = 1'b1;
        s_if.flip_ena = 1'b0;
        s_if.nmi_ena  = 1'b1;
        d_if.flip_ena = 1'b1;   // never reaches (0,0) in this run, so never latched
        d_if.nmi_ena  = 1'b1;   // no strobe on lines 0..1, so no NMI
        repeat (2) @(negedge clk);
        chk_s_reset();
        chk_d_reset();

        // Step 2: release and run; k = number of rising edges since release.
        //   Small instance schedule (frame = 192 clks, frame_stb at k%192==128):
        //     flip_ena 1 for k in [83,250): latched at the 192 wrap, dropped
        //       before the 384 wrap -> flip_out 1 exactly for k in [192,384)
        //     nmi_ena: 1 until k=140 (NMI at 128, cleared at 141);
        //       1 for [300,319) then 0 on the strobe edge at 320 (no NMI);
        //       rises at 322 mid-vblank -> next NMI only at 512 and held.
        rst = 1'b0;
        for (k = 0; k <= 800; k++) begin
            hs = k % SH_TOT;
            vs = (k / SH_TOT) % SV_TOT;
            fm = (k >= S_FRAME) && (k < 2 * S_FRAME);
`ifdef VIDTIMING_NMI_EN
            nm = !(((k >= 128) && (k <= 140)) || (k >= 512));
`else
            nm = 1'b1;
`endif
            hb = (hs >= SH_ACT);
            vb = (vs < SVA_B) || (vs >= SVA_E);
            chk("s_htiming",   32'(s_if.htiming),   32'(hs));
            chk("s_vtiming",   32'(s_if.vtiming),   32'(vs));
            chk("s_vtiming_f", 32'(s_if.vtiming_f), 32'(vs ^ (fm ? 'hFF : 0)));
            chk("s_flip_out",  32'(s_if.flip_out),  32'(fm));
            chk("s_hblank",    32'(s_if.hblank),    32'(hb));
            chk("s_vblank",    32'(s_if.vblank),    32'(vb));
            chk("s_cmpblk",    32'(s_if.cmpblk),    32'(hb | vb));
            chk("s_hsync_n",   32'(s_if.hsync_n),   32'(!((hs >= SHS_B) && (hs < SHS_B + SHS_L))));
            chk("s_vsync_n",   32'(s_if.vsync_n),   32'(!((vs >= SVS_B) && (vs < SVS_B + SVS_L))));
            chk("s_frame_stb", 32'(s_if.frame_stb), 32'((vs == SVA_E) && (hs == 0)));
            chk("s_nmi_n",     32'(s_if.nmi_n),     32'(nm));

            // Default raster: only lines 0 and 1 are visited, both blank.
            hd = k % 768;
            vd = k / 768;
            chk("d_htiming",   32'(d_if.htiming),   32'(hd));
            chk("d_vtiming",   32'(d_if.vtiming),   32'(vd));
            chk("d_vtiming_f", 32'(d_if.vtiming_f), 32'(vd));
            chk("d_flip_out",  32'(d_if.flip_out),  32'd0);
            chk("d_hblank",    32'(d_if.hblank),    32'(hd >= 'h200));
            chk("d_cmpblk",    32'(d_if.cmpblk),    32'd1);
            chk("d_hsync_n",   32'(d_if.hsync_n),   32'(!((hd >= 'h240) && (hd < 'h280))));
            chk("d_vsync_n",   32'(d_if.vsync_n),   32'd1);
            chk("d_frame_stb", 32'(d_if.frame_stb), 32'd0);
            chk("d_nmi_n",     32'(d_if.nmi_n),     32'd1);

            s_if.flip_ena = (k >= 83) && (k < 250);
            s_if.nmi_ena  = (k < 140) || ((k >= 300) && (k < 319)) || (k >= 322);
            @(negedge clk);
        end

        // Step 3: asynchronous reset mid-line (small at line 2 clk 1 with
        // NMI low, default at htiming 33 line 1); takes effect without a clock.
        #2 rst = 1'b1;
        #1;
        chk_s_reset();
        chk_d_reset();

        // Step 4: release and count three clocks from (0,0)
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        k = 3;
        chk("s_restart_htiming", 32'(s_if.htiming), 32'd3);
        chk("s_restart_vtiming", 32'(s_if.vtiming), 32'd0);
        chk("s_restart_cmpblk",  32'(s_if.cmpblk),  32'd1);
        chk("d_restart_htiming", 32'(d_if.htiming), 32'd3);
        chk("d_restart_vtiming", 32'(d_if.vtiming), 32'd0);
        chk("d_restart_cmpblk",  32'(d_if.cmpblk),  32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
